// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_sign_mag.sv
// Splits one operand into magnitude and sign; a plain pass-through in unsigned mode.
module mult_sign_mag #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] val,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  // The most-negative value maps onto 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    sign = signed_mode & val[WIDTH-1];
    mag  = sign ? WIDTH'(~val + 1'b1) : val;
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add multiplier: one partial product per cycle, valid/ready on both sides.
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   RUN   | WIDTH accumulate steps, inputs ignored
//   DONE  | product presented, held until out_ready
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  mult_state_t      state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    p_q, p_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_sign, b_sign;
  logic [PW-1:0]    acc_step;

  mult_sign_mag #(.WIDTH(WIDTH)) u_sm_a (
    .val         (a),
    .signed_mode (signed_mode),
    .mag         (a_mag),
    .sign        (a_sign)
  );

  mult_sign_mag #(.WIDTH(WIDTH)) u_sm_b (
    .val         (b),
    .signed_mode (signed_mode),
    .mag         (b_mag),
    .sign        (b_sign)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    p_d      = p_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = RUN;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = a_sign ^ b_sign;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last step: the sign is applied to the completed sum, modulo 2^PW.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          p_d     = neg_q ? PW'(-acc_step) : acc_step;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN) || (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = p_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized bench for mult_seq_ctrl against an integer-arithmetic reference product.
module tb_mult_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b;
  logic       signed_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] p;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  mult_seq_ctrl #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] ref_p(input logic [3:0] x, input logic [3:0] y, input logic sm);
    int          ix, iy;
    logic [31:0] pr;
    ix = (sm && x[3]) ? int'(x) - 16 : int'(x);
    iy = (sm && y[3]) ? int'(y) - 16 : int'(y);
    pr = ix * iy;
    return pr[7:0];
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_p"},         p,         0);
  endtask

  // One full transaction: accept, fixed-latency result, optional back-pressure, handoff.
  task automatic do_op(input logic [3:0] ia, input logic [3:0] ib, input logic ism,
                       input int stall, input bit poke);
    logic [7:0] ex;
    int         lat;
    int         g;
    ex = ref_p(ia, ib, ism);
    g  = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_idle", in_ready, 1);
    a = ia; b = ib; signed_mode = ism; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid    = 1'b0;
    a           = 4'($urandom);
    b           = 4'($urandom);
    signed_mode = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk("busy_run", busy, 1);
      chk("in_ready_run", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 5);
    chk("p", p, ex);
    for (int s = 0; s < stall; s++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_p", p, ex);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_busy", busy, 1);
      if (poke) begin
        in_valid = 1'b1;
        a = 4'($urandom);
        b = 4'($urandom);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("done_out_valid", out_valid, 1);
    chk("done_p", p, ex);
    @(negedge clk);
    out_ready = 1'b0;
    chk("drop_out_valid", out_valid, 0);
    chk("back_in_ready", in_ready, 1);
    chk("back_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");

    do_op(4'hF, 4'hF, 1'b0, 0, 1'b0);
    do_op(4'h8, 4'h8, 1'b1, 0, 1'b0);
    do_op(4'h8, 4'h7, 1'b1, 0, 1'b0);
    do_op(4'hD, 4'h5, 1'b1, 0, 1'b0);
    do_op(4'h0, 4'hF, 1'b1, 0, 1'b0);
    do_op(4'h6, 4'hB, 1'b0, 10, 1'b1);

    // Abort during the second RUN cycle.
    a = 4'hF; b = 4'hF; signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort_release");
    do_op(4'h3, 4'h4, 1'b0, 0, 1'b0);

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 256; i++) begin
        logic [7:0] ab;
        logic       sm;
        ab = i[7:0];
        sm = (m == 1);
        do_op(ab[7:4], ab[3:0], sm, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequential shift-and-add controller that computes the product of two WIDTH-bit operands over WIDTH clock cycles. The operands are unsigned or two's-complement.
- It sits between the switch/operand registers and the 7-segment display path. It replaces the single-cycle combinational multiplier where area or timing is tight.
- Operands enter on a valid/ready handshake, and the product leaves on a valid/ready handshake.

Parameters:
- WIDTH, 4, operand width in bits; the product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the step counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands A/B/signed_mode are valid.
- in_ready  output  1  controller can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = treat a and b as two's-complement; 0 = unsigned.
- out_valid  output  1  product is valid; high only in DONE.
- out_ready  input  1  consumer accepts the product.
- p  output  2*WIDTH  product; two's-complement when signed_mode was 1 at accept.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, p=0.
  - All internal registers (accumulator, shifted multiplicand, multiplier, counter, sign flag) are 0.
- Reset asserted mid-operation aborts immediately; no partial product is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a cycle with in_valid=1 (accept cycle C0), the controller captures the following and moves to RUN:
    - mag_a = |a| and mag_b = |b| when signed_mode=1; otherwise a and b unchanged.
    - neg = signed_mode & (a[MSB] ^ b[MSB]).
    - acc=0, cnt=0.
  - Magnitude of the most-negative value (e.g. -8 for WIDTH=4) is 2^(WIDTH-1). It fits unsigned in WIDTH bits, so no special case is needed.
- RUN, one step per cycle during C1..C_WIDTH:
  - If mag_b[0]=1, then acc += mcand, where mcand is 2*WIDTH bits, zero-extended from mag_a.
  - Then mcand <<= 1, mag_b >>= 1, cnt += 1.
  - in_valid is ignored (in_ready=0).
  - On the step where cnt==WIDTH-1, the final accumulate completes and the controller moves to DONE.
  - At that same edge, p is loaded with neg ? -acc_final : acc_final, computed modulo 2^(2*WIDTH).
- Latency: out_valid first high in cycle C_(WIDTH+1), i.e. WIDTH+1 cycles after the accept cycle. It is fixed and independent of operand values; there is no early termination.
- DONE:
  - out_valid=1; p is held stable.
  - When out_ready=1, the controller moves to IDLE the next edge, and out_valid drops.
  - With out_ready=0, the controller waits indefinitely with p and out_valid stable.
- in_ready returns high only in IDLE. Accept and output happen on separate cycles, so minimum throughput is one product per WIDTH+2 cycles.
- in_valid asserted during RUN/DONE is not queued; the requester must hold it until in_ready.
- signed_mode, a and b are sampled only at accept. Changes afterwards do not affect the current product.
- Width rules:
  - Unsigned: max product (2^WIDTH-1)^2 fits 2*WIDTH bits.
  - Signed: range -2^(2W-2)+2^(W-1) .. 2^(2W-2) fits signed 2*WIDTH bits. (-8)*(-8) = +64 = 0x40.
  - No overflow is possible and there is no overflow flag.
- Zero operand: still takes the full WIDTH steps; p=0. A negative zero never occurs, because -0 = 0 mod 2^(2W).
- Unreachable state encodings return to IDLE.

Decomposition:
- Package mult_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t.
  - Default WIDTH constant.
- One sub-module, mult_sign_mag: combinational abs value plus sign extraction for one operand, instantiated twice at accept.
- The final negate is done inline.

Test Plan:
- Unsigned 15*15: a=4'hF, b=4'hF, signed_mode=0, out_ready=1 → out_valid rises exactly 5 cycles after the accept cycle; p=8'hE1 (225); busy high for RUN+DONE.
- Signed extremes: a=4'b1000 (-8), b=4'b1000, signed_mode=1 → p=8'h40 (64). Then a=-8, b=7 → p=8'hC8 (-56).
- Mixed sign and zero: a=-3 (4'hD), b=5, signed → p=8'hF1 (-15). Then a=0, b=-1, signed → p=8'h00, same 5-cycle latency.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → out_valid and p stable, in_ready=0. Pulse in_valid with new operands → ignored. Raise out_ready → IDLE next edge.
- Reset mid-operation: assert reset_n=0 during the 2nd RUN cycle → outputs go to reset values immediately (async). After release, the next operation 3*4 unsigned gives p=8'h0C with normal latency.
- Random sweep: all 256 a/b pairs in both modes, with random out_ready stalls → p matches the reference model, and every accept yields exactly one out_valid/out_ready transfer.
